shift_window: RTL

Parametrised shift register for the tiny-tapeout user area. It generalises the fixed 32-bit serial-in capture chain used in the top level. It adds selectable width, shift direction, rotate mode, parallel load, a shadow snapshot register and a frame counter that pulses every WIDTH shifts. The top level instantiates it between the dedicated input pins and the output pins, driving `uo_out` from `win`.

---
 rtl/shift_window.sv | 77 +++++++
 1 files changed

// File: rtl/shift_window.sv
// Parametrised shift register with rotate, parallel load, shadow snapshot
// and a frame counter that pulses once every WIDTH shifts.
module shift_window #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         dir,
    input  logic                         rot,
    input  logic                         sin,
    input  logic                         load,
    input  logic [WIDTH-1:0]             din,
    input  logic                         latch,
    output logic                         sout,
    output logic [OUT_W-1:0]             win,
    output logic [WIDTH-1:0]             snap,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         frame
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [CW-1:0]    count_q, count_d;
    logic             frame_q, frame_d;
    logic             b_in;

    assign sout  = dir ? shreg_q[0] : shreg_q[WIDTH-1];
    assign b_in  = rot ? sout : sin;
    assign win   = shreg_q[WIDTH-1 -: OUT_W];
    assign snap  = snap_q;
    assign count = count_q;
    assign frame = frame_q;

    always_comb begin
        shreg_d = shreg_q;
        count_d = count_q;
        frame_d = 1'b0;
        // Snapshot takes the pre-edge value, independent of load/shift.
        snap_d  = latch ? shreg_q : snap_q;

        if (load) begin
            shreg_d = din;
            count_d = '0;
        end else if (en) begin
            if (dir) begin
                shreg_d = {b_in, shreg_q[WIDTH-1:1]};
            end else begin
                shreg_d = {shreg_q[WIDTH-2:0], b_in};
            end
            if (count_q == CW'(WIDTH - 1)) begin
                count_d = '0;
                frame_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            snap_q  <= '0;
            count_q <= '0;
            frame_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            snap_q  <= snap_d;
            count_q <= count_d;
            frame_q <= frame_d;
        end
    end

endmodule
